// File: rtl/strobe_capture_pkg.sv
// Shared types and constants for the strobe capture queue.
//   chan_state_e : per-channel capture state
//   DROP_W/MAX   : width and saturation value of the drop counter
//   chan_w()     : channel-id width, at least one bit
package strobe_capture_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HELD  = 2'd2
  } chan_state_e;

  localparam int unsigned DROP_W = 8;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  function automatic int unsigned chan_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/strobe_capture_queue_if.sv
// Record output stream of the capture queue (valid/ready).
//   master : drives valid, chan, data, ts; samples ready
//   slave  : consumer side
interface strobe_capture_queue_if
  import strobe_capture_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned TS_W     = 16
);
  localparam int unsigned CHAN_W = chan_w(CHANNELS);

  logic              out_valid_o;
  logic              out_ready_i;
  logic [CHAN_W-1:0] out_chan_o;
  logic [WIDTH-1:0]  out_data_o;
  logic [TS_W-1:0]   out_ts_o;

  modport master (output out_valid_o, out_chan_o, out_data_o, out_ts_o, input out_ready_i);
  modport slave  (input out_valid_o, out_chan_o, out_data_o, out_ts_o, output out_ready_i);
endinterface

// File: rtl/strobe_capture_fifo.sv
// Synchronous FIFO with occupancy count; head reads zero when empty.
//   push/push_data : write, ignored when full
//   pop            : read, ignored when empty
//   head           : current head entry
//   count/full/empty : occupancy
module strobe_capture_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   cnt_q;
  logic             do_push, do_pop;

  assign full    = (cnt_q == (PTR_W+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (PTR_W+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PTR_W+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: unread entries are masked by empty
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/strobe_capture_queue.sv
// Multi-channel capture queue with display (sample now) and strobe
// (sample next cycle) semantics, round-robin into a shared FIFO.
//   req_i/strobe_mode_i/data_i : per-channel capture requests and values
//   rec                        : record stream {chan, data, ts}
//   drop_cnt_o                 : saturating count of dropped requests
//   busy_o                     : any channel active or FIFO non-empty
module strobe_capture_queue
  import strobe_capture_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned TS_W     = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       req_i,
  input  logic [CHANNELS-1:0]       strobe_mode_i,
  input  logic [CHANNELS*WIDTH-1:0] data_i,
  strobe_capture_queue_if.master    rec,
  output logic [DROP_W-1:0]         drop_cnt_o,
  output logic                      busy_o
);
  localparam int unsigned CHAN_W  = chan_w(CHANNELS);
  localparam int unsigned REC_W   = CHAN_W + WIDTH + TS_W;
  localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
  localparam int unsigned NDROP_W = $clog2(CHANNELS + 1);
  localparam int unsigned ACC_W   = DROP_W + NDROP_W;

  chan_state_e         state_q    [CHANNELS];
  chan_state_e         state_d    [CHANNELS];
  logic [WIDTH-1:0]    cap_data_q [CHANNELS];
  logic [WIDTH-1:0]    cap_data_d [CHANNELS];
  logic [TS_W-1:0]     cap_ts_q   [CHANNELS];
  logic [TS_W-1:0]     cap_ts_d   [CHANNELS];
  logic [WIDTH-1:0]    chan_data  [CHANNELS];
  logic [TS_W-1:0]     ts_q;
  logic [CHAN_W-1:0]   rr_q;
  logic [DROP_W-1:0]   drop_cnt_q, drop_d;
  logic [NDROP_W-1:0]  ndrop;
  logic [ACC_W-1:0]    drop_acc;
  logic                gnt_valid;
  logic [CHAN_W-1:0]   gnt_chan;
  logic [CHAN_W:0]     cand;
  logic                any_active;
  logic [REC_W-1:0]    fifo_head;
  logic [CNT_W-1:0]    fifo_count;
  logic                fifo_full, fifo_empty;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_slice
    assign chan_data[g] = data_i[g*WIDTH +: WIDTH];
  end

  // Round-robin search starting at rr_q; no grant while the FIFO is full
  always_comb begin
    gnt_valid = 1'b0;
    gnt_chan  = '0;
    cand      = '0;
    for (int j = 0; j < CHANNELS; j++) begin
      cand = {1'b0, rr_q} + (CHAN_W+1)'(j);
      if (cand >= (CHAN_W+1)'(CHANNELS)) cand = cand - (CHAN_W+1)'(CHANNELS);
      if (!gnt_valid && !fifo_full && state_q[cand[CHAN_W-1:0]] == HELD) begin
        gnt_valid = 1'b1;
        gnt_chan  = cand[CHAN_W-1:0];
      end
    end
  end

  // Channel next-state: a granted HELD channel accepts a new request as if IDLE
  always_comb begin
    ndrop = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      logic take, dropped;
      take          = 1'b0;
      dropped       = 1'b0;
      state_d[i]    = state_q[i];
      cap_data_d[i] = cap_data_q[i];
      cap_ts_d[i]   = cap_ts_q[i];
      case (state_q[i])
        IDLE: take = req_i[i];
        ARMED: begin
          state_d[i]    = HELD;
          cap_data_d[i] = chan_data[i];
          dropped       = req_i[i];
        end
        HELD: begin
          if (gnt_valid && gnt_chan == CHAN_W'(i)) begin
            state_d[i] = IDLE;
            take       = req_i[i];
          end else begin
            dropped = req_i[i];
          end
        end
        default: state_d[i] = IDLE;
      endcase
      if (take) begin
        cap_ts_d[i] = ts_q;
        if (strobe_mode_i[i]) begin
          state_d[i] = ARMED;
        end else begin
          state_d[i]    = HELD;
          cap_data_d[i] = chan_data[i];
        end
      end
      if (dropped) ndrop = ndrop + NDROP_W'(1);
    end
  end

  // Multiple same-cycle drops add together, saturating
  always_comb begin
    drop_acc = ACC_W'(drop_cnt_q) + ACC_W'(ndrop);
    drop_d   = (drop_acc > ACC_W'(DROP_MAX)) ? DROP_MAX : drop_acc[DROP_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i]    <= IDLE;
        cap_data_q[i] <= '0;
        cap_ts_q[i]   <= '0;
      end
      ts_q       <= '0;
      rr_q       <= '0;
      drop_cnt_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i]    <= state_d[i];
        cap_data_q[i] <= cap_data_d[i];
        cap_ts_q[i]   <= cap_ts_d[i];
      end
      ts_q       <= ts_q + TS_W'(1);
      drop_cnt_q <= drop_d;
      if (gnt_valid)
        rr_q <= (gnt_chan == CHAN_W'(CHANNELS - 1)) ? '0 : gnt_chan + CHAN_W'(1);
    end
  end

  strobe_capture_fifo #(.WIDTH(REC_W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (gnt_valid),
    .push_data ({gnt_chan, cap_data_q[gnt_chan], cap_ts_q[gnt_chan]}),
    .pop       (rec.out_ready_i),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    any_active = 1'b0;
    for (int i = 0; i < CHANNELS; i++)
      if (state_q[i] != IDLE) any_active = 1'b1;
  end

  assign rec.out_valid_o = ~fifo_empty;
  assign rec.out_chan_o  = fifo_head[REC_W-1 -: CHAN_W];
  assign rec.out_data_o  = fifo_head[TS_W +: WIDTH];
  assign rec.out_ts_o    = fifo_head[TS_W-1:0];
  assign drop_cnt_o      = drop_cnt_q;
  assign busy_o          = any_active | (fifo_count != '0);
endmodule

// File: tb/tb_strobe_capture_queue.sv
// Directed bench: vector table for display/strobe, contention and re-request,
// hand sequences for backpressure, drop saturation, reset and ts wrap.
module tb_strobe_capture_queue;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req, strb, req4, strb4;
  logic [127:0] data, data4;
  logic [7:0]   drop, drop4;
  logic         busy, busy4;

  always #5 clk = ~clk;

  strobe_capture_queue_if #(.WIDTH(32), .CHANNELS(4), .TS_W(16)) sif ();
  strobe_capture_queue_if #(.WIDTH(32), .CHANNELS(4), .TS_W(4))  sif4 ();

  strobe_capture_queue #(.WIDTH(32), .CHANNELS(4), .DEPTH(8), .TS_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .strobe_mode_i(strb), .data_i(data),
    .rec(sif), .drop_cnt_o(drop), .busy_o(busy));

  strobe_capture_queue #(.WIDTH(32), .CHANNELS(4), .DEPTH(8), .TS_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req_i(req4), .strobe_mode_i(strb4), .data_i(data4),
    .rec(sif4), .drop_cnt_o(drop4), .busy_o(busy4));

  typedef struct {
    logic         rst;
    logic [3:0]   req;
    logic [3:0]   strb;
    logic [127:0] data;
    logic         rdy;
    logic [63:0]  exp;
  } vec_t;

  vec_t vq[$];
  int   vec_cnt  = 0;
  int   fail_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] obs();
    return {4'b0, sif.out_valid_o, sif.out_chan_o, sif.out_data_o, sif.out_ts_o, drop, busy};
  endfunction

  function automatic logic [63:0] E(input int v, input int ch, input int d, input int ts,
                                    input int dr, input int b);
    return {4'b0, 1'(v), 2'(ch), 32'(d), 16'(ts), 8'(dr), 1'(b)};
  endfunction

  function automatic logic [127:0] d4(input int a, input int b, input int c, input int e);
    return {32'(e), 32'(c), 32'(b), 32'(a)};
  endfunction

  function automatic void add(input logic r, input logic [3:0] rq, input logic [3:0] sb,
                              input logic [127:0] d, input logic rd, input logic [63:0] e);
    vec_t v;
    v.rst = r; v.req = rq; v.strb = sb; v.data = d; v.rdy = rd; v.exp = e;
    vq.push_back(v);
  endfunction

  // Drive one cycle of main-DUT inputs at the falling edge, return just after the rising edge
  task automatic apply(input logic r, input logic [3:0] rq, input logic [3:0] sb,
                       input logic [127:0] d, input logic rd);
    @(negedge clk);
    rst_n = ~r;
    req = rq; strb = sb; data = d;
    sif.out_ready_i = rd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [127:0] dv;
    int n, cyc;
    rst_n = 1'b0;
    req = '0; strb = '0; data = '0;
    req4 = '0; strb4 = '0; data4 = '0;
    sif.out_ready_i = 1'b0;
    sif4.out_ready_i = 1'b0;

    // strobe samples the value of the following cycle, display the request cycle
    add(1, 4'h0, 4'h0, '0, 1, E(0, 0, 0, 0, 0, 0));
    add(0, 4'h1, 4'h1, d4(0, 0, 0, 0), 1, E(0, 0, 0, 0, 0, 1));
    add(0, 4'h0, 4'h0, d4(1, 0, 0, 0), 1, E(0, 0, 0, 0, 0, 1));
    add(0, 4'h0, 4'h0, d4(1, 0, 0, 0), 1, E(1, 0, 1, 0, 0, 1));
    add(0, 4'h0, 4'h0, d4(1, 0, 0, 0), 1, E(0, 0, 0, 0, 0, 0));
    add(0, 4'h1, 4'h0, d4(0, 0, 0, 0), 1, E(0, 0, 0, 0, 0, 1));
    add(0, 4'h0, 4'h0, d4(1, 0, 0, 0), 1, E(1, 0, 0, 4, 0, 1));
    add(0, 4'h0, 4'h0, d4(1, 0, 0, 0), 1, E(0, 0, 0, 0, 0, 0));
    // contention at ts=5, second burst at ts=11 restarts at ch0
    add(1, 4'h0, 4'h0, '0, 1, E(0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 5; k++) add(0, 4'h0, 4'h0, '0, 1, E(0, 0, 0, 0, 0, 0));
    add(0, 4'hf, 4'h0, d4(10, 11, 12, 13), 1, E(0, 0, 0, 0, 0, 1));
    for (int c = 0; c < 4; c++) add(0, 4'h0, 4'h0, '0, 1, E(1, c, 10 + c, 5, 0, 1));
    add(0, 4'h0, 4'h0, '0, 1, E(0, 0, 0, 0, 0, 0));
    add(0, 4'hf, 4'h0, d4(20, 21, 22, 23), 1, E(0, 0, 0, 0, 0, 1));
    for (int c = 0; c < 4; c++) add(0, 4'h0, 4'h0, '0, 1, E(1, c, 20 + c, 11, 0, 1));
    add(0, 4'h0, 4'h0, '0, 1, E(0, 0, 0, 0, 0, 0));
    // strobe re-request while ARMED is dropped; one record only
    add(1, 4'h0, 4'h0, '0, 1, E(0, 0, 0, 0, 0, 0));
    add(0, 4'h2, 4'h2, d4(0, 7, 0, 0), 1, E(0, 0, 0, 0, 0, 1));
    add(0, 4'h2, 4'h2, d4(0, 8, 0, 0), 1, E(0, 0, 0, 0, 1, 1));
    add(0, 4'h0, 4'h0, '0, 1, E(1, 1, 8, 0, 1, 1));
    add(0, 4'h0, 4'h0, '0, 1, E(0, 0, 0, 0, 1, 0));
    add(0, 4'h0, 4'h0, '0, 1, E(0, 0, 0, 0, 1, 0));

    foreach (vq[i]) begin
      apply(vq[i].rst, vq[i].req, vq[i].strb, vq[i].data, vq[i].rdy);
      check($sformatf("vec%0d", i), obs(), vq[i].exp);
    end

    // Backpressure: 12 requests, 8 fit in the FIFO, 4 channels left HELD
    apply(1, 4'h0, 4'h0, '0, 0);
    for (int k = 0; k < 12; k++) begin
      dv = '0;
      dv[(k % 4) * 32 +: 32] = 32'(100 + k);
      apply(0, 4'(1 << (k % 4)), 4'h0, dv, 0);
    end
    check("bp_full", obs(), E(1, 0, 100, 0, 0, 1));
    apply(0, 4'h3, 4'h0, '0, 0);
    apply(0, 4'h4, 4'h0, '0, 0);
    check("bp_drop", obs(), E(1, 0, 100, 0, 3, 1));

    // Four drops per cycle until well past saturation
    for (int k = 1; k <= 75; k++) begin
      apply(0, 4'hf, 4'h0, '0, 0);
      check($sformatf("sat%0d", k), {56'b0, drop}, 64'((3 + 4 * k > 255) ? 255 : 3 + 4 * k));
    end
    check("sat_head", obs(), E(1, 0, 100, 0, 255, 1));

    // Drain: every record in order, one per cycle
    n = 0;
    cyc = 0;
    for (int c = 0; c < 40 && n < 12; c++) begin
      if (sif.out_valid_o) begin
        check($sformatf("drain%0d", n), {27'b0, sif.out_chan_o, sif.out_data_o, 3'b0},
              {27'b0, 2'(n % 4), 32'(100 + n), 3'b0});
        check($sformatf("drain_ts%0d", n), 64'(sif.out_ts_o), 64'(n));
        n++;
      end
      apply(0, 4'h0, 4'h0, '0, 1);
      cyc++;
    end
    check("drain_count", 64'(n), 64'd12);
    check("drain_gaps", 64'(cyc), 64'd12);
    check("drain_empty", obs(), E(0, 0, 0, 0, 255, 0));

    // Reset mid-flight: 3 queued, ch2 ARMED
    apply(1, 4'h0, 4'h0, '0, 0);
    apply(0, 4'hb, 4'h0, d4(1, 2, 0, 4), 0);
    apply(0, 4'h0, 4'h0, '0, 0);
    apply(0, 4'h0, 4'h0, '0, 0);
    apply(0, 4'h4, 4'h4, '0, 0);
    check("mid_pre", obs(), E(1, 0, 1, 0, 0, 1));
    #2 rst_n = 1'b0;
    #1 check("mid_reset", obs(), E(0, 0, 0, 0, 0, 0));
    apply(0, 4'h2, 4'h0, d4(0, 55, 0, 0), 1);
    check("post_held", obs(), E(0, 0, 0, 0, 0, 1));
    apply(0, 4'h0, 4'h0, '0, 1);
    check("post_rec", obs(), E(1, 1, 55, 0, 0, 1));

    // 4-bit timestamp wraps between consecutive requests
    apply(1, 4'h0, 4'h0, '0, 1);
    sif4.out_ready_i = 1'b1;
    for (int k = 0; k < 15; k++) apply(0, 4'h0, 4'h0, '0, 1);
    req4 = 4'h1; data4 = d4(10, 0, 0, 0);
    apply(0, 4'h0, 4'h0, '0, 1);
    req4 = 4'h2; data4 = d4(0, 11, 0, 0);
    apply(0, 4'h0, 4'h0, '0, 1);
    check("wrap_a", {10'b0, sif4.out_valid_o, sif4.out_chan_o, sif4.out_data_o, sif4.out_ts_o, drop4, busy4},
          {10'b0, 1'b1, 2'd0, 32'd10, 4'd15, 8'd0, 1'b1});
    req4 = 4'h0;
    apply(0, 4'h0, 4'h0, '0, 1);
    check("wrap_b", {10'b0, sif4.out_valid_o, sif4.out_chan_o, sif4.out_data_o, sif4.out_ts_o, drop4, busy4},
          {10'b0, 1'b1, 2'd1, 32'd11, 4'd0, 8'd0, 1'b1});

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, fail_cnt);
    $finish;
  end
endmodule
